// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and defaults for the program run controller.
package prog_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3
  } run_state_t;

  localparam int CYC_W_DEF       = 16;
  localparam int WDOG_CYCLES_DEF = 4096;

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Handshake bundle between the run controller, the test harness, the decoder and the PC.
interface prog_run_ctrl_if
  import prog_run_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF
) ();

  logic             Start;
  logic             Halt;
  logic             StepMode;
  logic             StepReq;
  logic             CountEn;
  logic             Running;
  logic             Done;
  logic             Timeout;
  logic [CYC_W-1:0] CycleCount;

  modport master (
    output Start, Halt, StepMode, StepReq,
    input  CountEn, Running, Done, Timeout, CycleCount
  );

  modport slave (
    input  Start, Halt, StepMode, StepReq,
    output CountEn, Running, Done, Timeout, CycleCount
  );

endinterface

// File: rtl/prog_run_ctrl_rise_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level.
module rise_detect (
  input  logic clk,
  input  logic Reset,
  input  logic level,
  output logic pulse
);

  logic level_q_r;

  // History of the level from the previous cycle
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      level_q_r <= 1'b0;
    end else begin
      level_q_r <= level;
    end
  end

  assign pulse = level & ~level_q_r;

endmodule

// File: rtl/prog_run_ctrl.sv
// Run controller: Start handshake, Halt stop, single-step mode, saturating cycle count.
// Optional watchdog enabled by defining RUN_WDOG_EN.
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int CYC_W       = CYC_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input logic            clk,
  input logic            Reset,
  prog_run_ctrl_if.slave bus
);

  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  if (WDOG_CYCLES < 1 || WDOG_CYCLES >= (64'd1 << CYC_W)) begin : g_bad_wdog
    $error("WDOG_CYCLES must be in 1 .. 2**CYC_W-1");
  end

  run_state_t       state_r;
  run_state_t       state_nxt_s;
  logic             step_pulse_s;
  logic             advance_s;
  logic             halt_win_s;
  logic             in_run_s;
  logic             wdog_hit_s;
  logic             running_r;
  logic             done_r;
  logic [CYC_W-1:0] cycle_count_r;

  rise_detect u_step_rise (
    .clk   (clk),
    .Reset (Reset),
    .level (bus.StepReq),
    .pulse (step_pulse_s)
  );

  // The PC may act every cycle in free-run, only on a step pulse in step mode
  assign in_run_s   = (state_r == RUN);
  assign advance_s  = bus.StepMode ? step_pulse_s : 1'b1;
  assign halt_win_s = bus.Halt & advance_s;

  assign bus.CountEn = in_run_s & ~bus.Start & ~bus.Halt & advance_s;

`ifdef RUN_WDOG_EN
  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(WDOG_CYCLES - 1);
  logic timeout_r;

  assign wdog_hit_s = (cycle_count_r == WDOG_LAST);

  // Timeout latches when the watchdog ends a run and clears on re-arming
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      timeout_r <= 1'b0;
    end else if (state_nxt_s == ARMED) begin
      timeout_r <= 1'b0;
    end else if (in_run_s && !bus.Start && !halt_win_s && wdog_hit_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign bus.Timeout = timeout_r;
`else
  assign wdog_hit_s  = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  // Next-state decode; in RUN, Start beats Halt and Halt beats the watchdog
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) state_nxt_s = ARMED;
        else           state_nxt_s = IDLE;
      end
      ARMED: begin
        if (bus.Start) state_nxt_s = ARMED;
        else           state_nxt_s = RUN;
      end
      RUN: begin
        if (bus.Start)       state_nxt_s = ARMED;
        else if (halt_win_s) state_nxt_s = DONE;
        else if (wdog_hit_s) state_nxt_s = DONE;
        else                 state_nxt_s = RUN;
      end
      DONE: begin
        if (bus.Start) state_nxt_s = ARMED;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State plus status flags decoded from the next state
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == DONE);
    end
  end

  // Counts every edge taken in RUN, including the one that leaves it
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cycle_count_r <= {CYC_W{1'b0}};
    end else if (state_nxt_s == ARMED) begin
      cycle_count_r <= {CYC_W{1'b0}};
    end else if (in_run_s && cycle_count_r != CYC_MAX) begin
      cycle_count_r <= cycle_count_r + CYC_W'(1);
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign bus.Running    = running_r;
  assign bus.Done       = done_r;
  assign bus.CycleCount = cycle_count_r;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed self-checking bench for prog_run_ctrl (16-bit instance and a 4-bit/WDOG=8 instance).
module tb_prog_run_ctrl;

  logic clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   ce_cnt;

  always #5 clk = ~clk;

  prog_run_ctrl_if #(.CYC_W(16)) bus ();
  prog_run_ctrl_if #(.CYC_W(4))  bus4 ();

  prog_run_ctrl #(.CYC_W(16), .WDOG_CYCLES(4096)) dut (
    .clk(clk), .Reset(Reset), .bus(bus)
  );

  prog_run_ctrl #(.CYC_W(4), .WDOG_CYCLES(8)) dut4 (
    .clk(clk), .Reset(Reset), .bus(bus4)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    bus.Start = 1'b0;  bus.Halt = 1'b0;  bus.StepMode = 1'b0;  bus.StepReq = 1'b0;
    bus4.Start = 1'b0; bus4.Halt = 1'b0; bus4.StepMode = 1'b0; bus4.StepReq = 1'b0;
    #1;
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL rst_running: got %0d expected 0", bus.Running); end
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0d expected 0", bus.Done); end
    vectors++; if (bus.Timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %0d expected 0", bus.Timeout); end
    vectors++; if (bus.CycleCount !== 16'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", bus.CycleCount); end
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL rst_counten: got %0d expected 0", bus.CountEn); end
    repeat (2) tick();
    Reset = 1'b0;
    tick(); settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL idle_counten: got %0d expected 0", bus.CountEn); end
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL idle_running: got %0d expected 0", bus.Running); end
  endtask

  task automatic test_free_run;
    bus.Start = 1'b1;
    repeat (3) tick();
    settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL armed_counten: got %0d expected 0", bus.CountEn); end
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL armed_running: got %0d expected 0", bus.Running); end
    bus.Start = 1'b0;
    tick(); settle();
    vectors++; if (bus.Running !== 1'b1) begin miscompares++; $display("FAIL run_entry: got %0d expected 1", bus.Running); end
    vectors++; if (bus.CycleCount !== 16'd0) begin miscompares++; $display("FAIL run_count0: got %0d expected 0", bus.CycleCount); end
    for (int i = 0; i < 10; i++) begin
      settle();
      vectors++; if (bus.CountEn !== 1'b1) begin miscompares++; $display("FAIL free_counten[%0d]: got %0d expected 1", i, bus.CountEn); end
      tick();
    end
    bus.Halt = 1'b1;
    settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL halt_counten: got %0d expected 0", bus.CountEn); end
    vectors++; if (bus.CycleCount !== 16'd10) begin miscompares++; $display("FAIL halt_count: got %0d expected 10", bus.CycleCount); end
    tick(); settle();
    vectors++; if (bus.Done !== 1'b1) begin miscompares++; $display("FAIL done_flag: got %0d expected 1", bus.Done); end
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL done_running: got %0d expected 0", bus.Running); end
    vectors++; if (bus.CycleCount !== 16'd11) begin miscompares++; $display("FAIL done_count: got %0d expected 11", bus.CycleCount); end
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL done_counten: got %0d expected 0", bus.CountEn); end
    bus.Halt = 1'b0;
    tick(); settle();
    vectors++; if (bus.Done !== 1'b1) begin miscompares++; $display("FAIL done_hold: got %0d expected 1", bus.Done); end
    vectors++; if (bus.CycleCount !== 16'd11) begin miscompares++; $display("FAIL done_count_hold: got %0d expected 11", bus.CycleCount); end
  endtask

  task automatic test_step_mode;
    bus.StepMode = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick(); settle();
    vectors++; if (bus.Running !== 1'b1) begin miscompares++; $display("FAIL step_running: got %0d expected 1", bus.Running); end
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL step_idle_counten: got %0d expected 0", bus.CountEn); end
    ce_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      bus.StepReq = 1'b1;
      for (int h = 0; h < 3; h++) begin
        settle();
        if (bus.CountEn === 1'b1) ce_cnt++;
        vectors++; if (bus.CountEn !== (h == 0)) begin miscompares++; $display("FAIL step_pulse[%0d.%0d]: got %0d expected %0d", p, h, bus.CountEn, (h == 0)); end
        vectors++; if (bus.Running !== 1'b1) begin miscompares++; $display("FAIL step_run[%0d.%0d]: got %0d expected 1", p, h, bus.Running); end
        tick();
      end
      bus.StepReq = 1'b0;
      repeat (2) begin
        settle();
        if (bus.CountEn === 1'b1) ce_cnt++;
        tick();
      end
    end
    vectors++; if (ce_cnt !== 4) begin miscompares++; $display("FAIL step_total: got %0d expected 4", ce_cnt); end
    vectors++; if (bus.CycleCount !== 16'd20) begin miscompares++; $display("FAIL step_count: got %0d expected 20", bus.CycleCount); end
    bus.Halt = 1'b1;
    settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL step_halt_counten: got %0d expected 0", bus.CountEn); end
    tick(); settle();
    vectors++; if (bus.Running !== 1'b1) begin miscompares++; $display("FAIL step_halt_wait: got %0d expected 1", bus.Running); end
    bus.StepReq = 1'b1;
    settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL step_halt_pulse_counten: got %0d expected 0", bus.CountEn); end
    tick(); settle();
    vectors++; if (bus.Done !== 1'b1) begin miscompares++; $display("FAIL step_halt_done: got %0d expected 1", bus.Done); end
    vectors++; if (bus.CycleCount !== 16'd22) begin miscompares++; $display("FAIL step_halt_count: got %0d expected 22", bus.CycleCount); end
    bus.StepReq = 1'b0; bus.Halt = 1'b0; bus.StepMode = 1'b0;
  endtask

  task automatic test_abort;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    repeat (5) tick();
    settle();
    vectors++; if (bus.CycleCount !== 16'd5) begin miscompares++; $display("FAIL abort_pre_count: got %0d expected 5", bus.CycleCount); end
    bus.Start = 1'b1; bus.Halt = 1'b1;
    settle();
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL abort_counten: got %0d expected 0", bus.CountEn); end
    tick(); settle();
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %0d expected 0", bus.Done); end
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL abort_running: got %0d expected 0", bus.Running); end
    vectors++; if (bus.CycleCount !== 16'd0) begin miscompares++; $display("FAIL abort_count: got %0d expected 0", bus.CycleCount); end
    bus.Start = 1'b0; bus.Halt = 1'b0;
    tick(); settle();
    vectors++; if (bus.Running !== 1'b1) begin miscompares++; $display("FAIL rerun_running: got %0d expected 1", bus.Running); end
    vectors++; if (bus.CountEn !== 1'b1) begin miscompares++; $display("FAIL rerun_counten: got %0d expected 1", bus.CountEn); end
  endtask

  task automatic test_reset_midrun;
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL midrst_running: got %0d expected 0", bus.Running); end
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL midrst_counten: got %0d expected 0", bus.CountEn); end
    vectors++; if (bus.CycleCount !== 16'd0) begin miscompares++; $display("FAIL midrst_count: got %0d expected 0", bus.CycleCount); end
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %0d expected 0", bus.Done); end
    tick();
    Reset = 1'b0;
    tick(); settle();
    vectors++; if (bus.Running !== 1'b0) begin miscompares++; $display("FAIL postrst_running: got %0d expected 0", bus.Running); end
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL postrst_done: got %0d expected 0", bus.Done); end
    vectors++; if (bus.CountEn !== 1'b0) begin miscompares++; $display("FAIL postrst_counten: got %0d expected 0", bus.CountEn); end
  endtask

  task automatic test_saturate_wdog;
    bus4.Start = 1'b1;
    tick();
    bus4.Start = 1'b0;
    tick();
`ifdef RUN_WDOG_EN
    repeat (7) tick();
    settle();
    vectors++; if (bus4.Running !== 1'b1) begin miscompares++; $display("FAIL wdog_pre_running: got %0d expected 1", bus4.Running); end
    vectors++; if (bus4.CycleCount !== 4'd7) begin miscompares++; $display("FAIL wdog_pre_count: got %0d expected 7", bus4.CycleCount); end
    tick(); settle();
    vectors++; if (bus4.Done !== 1'b1) begin miscompares++; $display("FAIL wdog_done: got %0d expected 1", bus4.Done); end
    vectors++; if (bus4.Timeout !== 1'b1) begin miscompares++; $display("FAIL wdog_timeout: got %0d expected 1", bus4.Timeout); end
    vectors++; if (bus4.CycleCount !== 4'd8) begin miscompares++; $display("FAIL wdog_count: got %0d expected 8", bus4.CycleCount); end
    vectors++; if (bus4.CountEn !== 1'b0) begin miscompares++; $display("FAIL wdog_counten: got %0d expected 0", bus4.CountEn); end
`else
    repeat (20) tick();
    settle();
    vectors++; if (bus4.CycleCount !== 4'd15) begin miscompares++; $display("FAIL sat_count: got %0d expected 15", bus4.CycleCount); end
    vectors++; if (bus4.Running !== 1'b1) begin miscompares++; $display("FAIL sat_running: got %0d expected 1", bus4.Running); end
    vectors++; if (bus4.Timeout !== 1'b0) begin miscompares++; $display("FAIL sat_timeout: got %0d expected 0", bus4.Timeout); end
`endif
    bus4.Start = 1'b1;
    tick(); settle();
    vectors++; if (bus4.Timeout !== 1'b0) begin miscompares++; $display("FAIL rearm_timeout: got %0d expected 0", bus4.Timeout); end
    vectors++; if (bus4.CycleCount !== 4'd0) begin miscompares++; $display("FAIL rearm_count: got %0d expected 0", bus4.CycleCount); end
    bus4.Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step_mode();
    test_abort();
    test_reset_midrun();
    test_saturate_wdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
